// File: rtl/layer_output_serializer.sv
// -----------------------------------------------------------------------------
// layer_output_serializer
//
// Purpose:
//   Sits between one layer of neuron instances and the next. Each neuron
//   reports its activation once (out/outvalid pulse) at its own time; this block
//   holds every value until the whole layer has reported. It then replays the
//   values one per cycle, neuron 0 first, as the serial myinput/myinputValid
//   stream that every neuron of the next layer consumes. This hides the
//   per-neuron completion skew from the next layer.
//
// Parameters:
//   numNeurons  neurons in the producing layer (1..1024)
//   dataWidth   width of one activation value
//   idxWidth    width of the neuron index counter ($clog2(numNeurons), min 1)
//
// Ports:
//   clk             clock
//   rst             synchronous, active-high reset
//   x_in            packed neuron outputs, neuron i at x_in[i*dataWidth +: dataWidth]
//   x_valid         per-neuron outvalid pulses
//   data_out        serial activation to the next layer (holds when not valid)
//   data_out_valid  serial valid to the next layer
//   busy            high while the stream is being sent
//   overrun         sticky: a neuron result arrived when it could not be stored
//   argmax_out      index of the largest activation of the last stream
//   argmax_valid    one-cycle pulse, argmax_out valid
//
// Optional feature (macro SER_ARGMAX_EN):
//   When defined, the largest value of each stream (unsigned compare, ties keep
//   the lower index) is tracked and its index is reported on argmax_out with an
//   argmax_valid pulse the cycle after the last data_out_valid cycle. When
//   undefined, the argmax ports and logic do not exist; the serial behaviour is
//   identical either way.
//
// There is no backpressure: the next layer must take one word per cycle.
// -----------------------------------------------------------------------------
module layer_output_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int idxWidth   = (numNeurons > 1) ? $clog2(numNeurons) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  x_in,
    input  logic [numNeurons-1:0]            x_valid,
    output logic [dataWidth-1:0]             data_out,
    output logic                             data_out_valid,
    output logic                             busy,
    output logic                             overrun
`ifdef SER_ARGMAX_EN
    ,
    output logic [idxWidth-1:0]              argmax_out,
    output logic                             argmax_valid
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numNeurons - 1);

    state_t                 state_reg, state_next;
    logic [idxWidth-1:0]    cnt_reg, cnt_next;
    logic [numNeurons-1:0]  flag_reg, flag_next;
    logic [dataWidth-1:0]   buf_reg [numNeurons];
    logic [dataWidth-1:0]   data_out_reg;
    logic                   data_out_valid_reg;
    logic                   overrun_reg;

    logic [numNeurons-1:0]  capture;
    logic [numNeurons-1:0]  drop;
    logic                   in_send;
    logic                   last_word;
    logic [dataWidth-1:0]   word_sel;

    assign in_send   = (state_reg == SEND);
    // The final word of a stream is being registered at this edge.
    assign last_word = in_send && (cnt_reg == LAST_IDX);
    assign word_sel  = buf_reg[cnt_reg];

    // -------------------------------------------------------------------------
    // Per-neuron capture / drop decisions and next flag value.
    // A pulse is stored only if that neuron has not reported yet this round and
    // the block is collecting; anything else is dropped and flagged as overrun.
    // Flags are released on the edge that emits the last word, so capture for
    // the next round starts the cycle after the return to COLLECT.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < numNeurons; gi++) begin : g_neuron
            assign capture[gi]   = x_valid[gi] && !flag_reg[gi] && !in_send;
            assign drop[gi]      = x_valid[gi] && ( flag_reg[gi] ||  in_send);
            assign flag_next[gi] = last_word ? 1'b0 : (flag_reg[gi] || capture[gi]);
        end
    endgenerate

    // Holding buffer: no reset needed, every entry is written before it is read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeurons; i++) begin
            if (!rst && capture[i]) begin
                buf_reg[i] <= x_in[i*dataWidth +: dataWidth];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register and counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
            cnt_reg   <= '0;
            flag_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            flag_reg  <= flag_next;
        end
    end

    // Leaving COLLECT looks at the registered flags, so the last capture edge
    // is followed by one more edge before SEND begins.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            COLLECT: begin
                cnt_next = '0;
                if (&flag_reg) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (cnt_reg == LAST_IDX) begin
                    cnt_next   = '0;
                    state_next = COLLECT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = COLLECT;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered serial output and sticky overrun
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg       <= '0;
            data_out_valid_reg <= 1'b0;
            overrun_reg        <= 1'b0;
        end else begin
            data_out_valid_reg <= in_send;
            if (in_send) begin
                data_out_reg <= word_sel;
            end
            if (|drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign data_out       = data_out_reg;
    assign data_out_valid = data_out_valid_reg;
    assign overrun        = overrun_reg;
    assign busy           = in_send;

`ifdef SER_ARGMAX_EN
    // -------------------------------------------------------------------------
    // Running maximum over the words as they are sent. The first word of a
    // stream always seeds the tracker; afterwards only a strictly greater value
    // replaces it, so ties keep the lower index. The result is published one
    // edge after the last word, i.e. together with data_out_valid falling.
    // -------------------------------------------------------------------------
    logic [dataWidth-1:0] best_val_reg;
    logic [idxWidth-1:0]  best_idx_reg;
    logic [idxWidth-1:0]  argmax_out_reg;
    logic                 argmax_pending_reg;
    logic                 argmax_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            best_val_reg       <= '0;
            best_idx_reg       <= '0;
            argmax_out_reg     <= '0;
            argmax_pending_reg <= 1'b0;
            argmax_valid_reg   <= 1'b0;
        end else begin
            argmax_pending_reg <= last_word;
            argmax_valid_reg   <= argmax_pending_reg;
            if (argmax_pending_reg) begin
                argmax_out_reg <= best_idx_reg;
            end
            if (in_send && ((cnt_reg == '0) || (word_sel > best_val_reg))) begin
                best_val_reg <= word_sel;
                best_idx_reg <= cnt_reg;
            end
        end
    end

    assign argmax_out   = argmax_out_reg;
    assign argmax_valid = argmax_valid_reg;
`endif

endmodule
